// File: rtl/counter_fib_seg_top_if.sv
// Signal bundle between the demo top and the board wrapper: the switch input
// and the counter and decoder outputs.
interface counter_fib_seg_top_if;
    logic       switch_in;
    logic [3:0] count;
    logic [6:0] switch_out;
    logic       fib_out;
    logic [6:0] BCD7_out;

    modport master (
        output switch_in,
        input  count,
        input  switch_out,
        input  fib_out,
        input  BCD7_out
    );

    modport slave (
        input  switch_in,
        output count,
        output switch_out,
        output fib_out,
        output BCD7_out
    );
endinterface

// File: rtl/counter_fib_seg_top.sv
// Board demo: free-running 4-bit counter feeding a Fibonacci flag and a hex
// seven-segment decoder, plus a 7-bit history of the slide switch.
module counter_fib_seg_top (
    input  logic                  clk,
    input  logic                  reset,
    counter_fib_seg_top_if.slave  bus
);

    logic [3:0] r_count;
    logic [6:0] r_switch;
    logic       w_fib;
    logic [6:0] w_seg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= 4'd0;
            r_switch <= 7'd0;
        end else begin
            r_count  <= r_count + 4'd1;
            r_switch <= {r_switch[5:0], bus.switch_in};
        end
    end

    always_comb begin
        w_fib = 1'b0;
        case (r_count)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13: w_fib = 1'b1;
            default:                                   w_fib = 1'b0;
        endcase
    end

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    always_comb begin
        w_seg = 7'h40;
        case (r_count)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h40;
        endcase
    end

    assign bus.count      = r_count;
    assign bus.switch_out = r_switch;
    assign bus.fib_out    = w_fib;
    assign bus.BCD7_out   = w_seg;

endmodule

// File: tb/tb_counter_fib_seg_top.sv
// Self-checking bench for counter_fib_seg_top: an arithmetic reference model
// checked every cycle, plus directed literal expectations.
module tb_counter_fib_seg_top;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    counter_fib_seg_top_if bus ();

    counter_fib_seg_top dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic bit is_fib(int n);
        int a = 0;
        int b = 1;
        int t;
        while (a < n) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a == n;
    endfunction

    task automatic check(string name, int actual, int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: count as an integer modulo 16, switch history as an
    // integer that gains one new low bit per clock and keeps seven bits.
    int m_count;
    int m_hist;
    bit m_valid;

    initial begin
        m_count = 0;
        m_hist  = 0;
        m_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            m_count = 0;
            m_hist  = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_count = (m_count + 1) % 16;
            m_hist  = (m_hist * 2 + int'(bus.switch_in)) % 128;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_count",      int'(bus.count),      m_count);
            check("model_switch_out", int'(bus.switch_out), m_hist);
            check("model_fib",        int'(bus.fib_out),    int'(is_fib(m_count)));
            check("model_bcd7",       int'(bus.BCD7_out),   int'(seg_tab[m_count]));
        end
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'bx;
        bus.switch_in = 1'bx;
        repeat (2) @(negedge clk);

        // Reset held three clocks with the switch high
        reset         = 1'b1;
        bus.switch_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_count",  int'(bus.count),      0);
            check("rst_switch", int'(bus.switch_out), 0);
            check("rst_fib",    int'(bus.fib_out),    1);
            check("rst_bcd7",   int'(bus.BCD7_out),   'h40);
        end

        // Release with a one-clock pulse on the switch, then sweep 17 edges
        reset         = 1'b0;
        bus.switch_in = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            bus.switch_in = 1'b0;
            check("sweep_count", int'(bus.count), n % 16);
            if (n <= 7)
                check("shift_walk", int'(bus.switch_out), 1 << (n - 1));
            else
                check("shift_clear", int'(bus.switch_out), 0);
            if (n == 4)  check("fib_at_4",  int'(bus.fib_out), 0);
            if (n == 13) check("fib_at_13", int'(bus.fib_out), 1);
            if (n == 14) check("fib_at_14", int'(bus.fib_out), 0);
            if (n == 10) check("bcd7_at_A", int'(bus.BCD7_out), 'h08);
            if (n == 15) check("bcd7_at_F", int'(bus.BCD7_out), 'h0E);
            if (n == 16) check("wrap_bcd7", int'(bus.BCD7_out), 'h40);
        end

        // Run up to count 9 with the switch high, then a one-edge reset
        bus.switch_in = 1'b1;
        repeat (8) @(negedge clk);
        check("pre_reset_count",  int'(bus.count),      9);
        check("pre_reset_switch", int'(bus.switch_out), 'h7F);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_count",  int'(bus.count),      0);
        check("mid_reset_switch", int'(bus.switch_out), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_count",  int'(bus.count),      1);
        check("post_reset_switch", int'(bus.switch_out), 1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
